// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts an opcode over a valid/ready handshake and decodes it
// into a one-hot select for the ALU output multiplexer. The select is held for the
// operation's settle time, one cycle for logic/add/sub and MULT_LAT cycles for
// multiply. The multiplexer output is then captured and offered on a result
// valid/ready handshake. Opcode 7 is illegal: it skips execution and returns a
// zero result with op_err set.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int K        = 7,
    parameter int MULT_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   opcode,
    output logic [6:0]   sel,
    input  logic [K-1:0] mux_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [K-1:0] result,
    output logic         op_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // The hold count must fit the 4-bit counter and be at least 1. A count of
    // 0 would never reach the capture condition, so an out-of-range MULT_LAT is
    // clamped rather than allowed to lock up EXEC.
    localparam int         MULT_CLAMP = (MULT_LAT < 1)  ? 1  :
                                        (MULT_LAT > 15) ? 15 : MULT_LAT;
    localparam logic [3:0] MULT_CNT   = 4'(MULT_CLAMP);

    state_t     state;
    logic [3:0] cnt;

    // Handshake and status flags decode directly from the state register.
    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Sequencer FSM. It owns the select, the hold counter, the result register
    // and the response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            sel       <= 7'd0;
            result    <= '0;
            op_err    <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (opcode == OP_ILLEGAL) begin
                            // There is nothing to execute, so go straight to the response.
                            result    <= '0;
                            op_err    <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            sel   <= 7'b1 << opcode;
                            cnt   <= (opcode == OP_MULT) ? MULT_CNT : 4'd1;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd1) begin
                        // Capture edge: the select has been stable for the full count.
                        result    <= mux_out;
                        op_err    <= 1'b0;
                        sel       <= 7'd0;
                        cnt       <= 4'd0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    sel       <= 7'd0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. A transaction-level model predicts the outputs
// from accept times and capture deadlines. A compare process checks the DUT
// against the model on every cycle. Directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int K        = 7;
    localparam int MULT_LAT = 3;

    logic         clk;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   opcode;
    logic [6:0]   sel;
    logic [K-1:0] mux_out;
    logic         res_valid;
    logic         res_ready;
    logic [K-1:0] result;
    logic         op_err;
    logic         busy;

    int tests = 0;
    int fails = 0;

    alu_op_sequencer #(.K(K), .MULT_LAT(MULT_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .sel       (sel),
        .mux_out   (mux_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .op_err    (op_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: when an opcode is accepted, it records the edge at which the result
    // is due. The result is taken from mux_out at that edge, and the response
    // is released on the first edge that sees res_ready.
    logic         m_rdy;
    logic [6:0]   m_sel;
    logic         m_rv;
    logic [K-1:0] m_res;
    logic         m_err;
    int           cap_at;
    int           cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy  <= 1'b1;
            m_sel  <= 7'd0;
            m_rv   <= 1'b0;
            m_res  <= '0;
            m_err  <= 1'b0;
            cap_at <= -1;
            cyc    <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_rdy && op_valid) begin
                m_rdy <= 1'b0;
                if (opcode == 3'd7) begin
                    m_res <= '0;
                    m_err <= 1'b1;
                    m_rv  <= 1'b1;
                end else begin
                    m_sel  <= 7'(1) << opcode;
                    cap_at <= cyc + ((opcode == 3'd6) ? MULT_LAT : 1);
                end
            end else if (cap_at == cyc) begin
                m_res  <= mux_out;
                m_err  <= 1'b0;
                m_sel  <= 7'd0;
                m_rv   <= 1'b1;
                cap_at <= -1;
            end else if (m_rv && res_ready) begin
                m_rv  <= 1'b0;
                m_rdy <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_sel", sel, m_sel);
            chk("cyc_op_ready", op_ready, m_rdy);
            chk("cyc_res_valid", res_valid, m_rv);
            chk("cyc_result", result, m_res);
            chk("cyc_op_err", op_err, m_err);
            chk("cyc_busy", busy, !m_rdy);
            chk("cyc_sel_onehot", ($countones(sel) <= 1), 1'b1);
        end
    end

    // Record the results the DUT hands over during the streaming run.
    logic         collect;
    logic [K-1:0] dq[$];
    always @(posedge clk) begin
        if (rst_n && collect && res_valid && res_ready) dq.push_back(result);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; opcode = 3'd0; mux_out = '0; res_ready = 1'b0;
        collect = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_sel", sel, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Logic op: XOR
        op_valid = 1'b1; opcode = 3'd2; mux_out = 7'h55; res_ready = 1'b1;
        @(negedge clk); op_valid = 1'b0;
        chk("logic_sel", sel, 7'b0000100);
        chk("logic_busy", busy, 1);
        @(negedge clk);
        chk("logic_sel_off", sel, 0);
        chk("logic_rv", res_valid, 1);
        chk("logic_result", result, 7'h55);
        chk("logic_err", op_err, 0);
        @(negedge clk);
        chk("logic_rv_drop", res_valid, 0);
        chk("logic_ready", op_ready, 1);

        // Multiply: mux_out settles late
        op_valid = 1'b1; opcode = 3'd6; mux_out = 7'h11;
        @(negedge clk); op_valid = 1'b0;
        chk("mult_sel1", sel, 7'b1000000); mux_out = 7'h33;
        @(negedge clk);
        chk("mult_sel2", sel, 7'b1000000); mux_out = 7'h2A;
        @(negedge clk);
        chk("mult_sel3", sel, 7'b1000000);
        @(negedge clk);
        chk("mult_sel_off", sel, 0);
        chk("mult_rv", res_valid, 1);
        chk("mult_result", result, 7'h2A);
        @(negedge clk);
        chk("mult_rv_drop", res_valid, 0);

        // Illegal opcode
        op_valid = 1'b1; opcode = 3'd7; mux_out = 7'h7F; res_ready = 1'b0;
        @(negedge clk); op_valid = 1'b0;
        chk("ill_sel", sel, 0);
        chk("ill_rv", res_valid, 1);
        chk("ill_err", op_err, 1);
        chk("ill_result", result, 0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("ill_rv_drop", res_valid, 0);

        // Back-pressure with op_valid held high
        op_valid = 1'b1; opcode = 3'd4; mux_out = 7'h3C; res_ready = 1'b0;
        @(negedge clk);
        chk("bp_sel", sel, 7'b0010000);
        opcode = 3'd5;
        @(negedge clk);
        chk("bp_rv", res_valid, 1);
        chk("bp_result", result, 7'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_rv", res_valid, 1);
            chk("bp_hold_result", result, 7'h3C);
            chk("bp_hold_err", op_err, 0);
            chk("bp_hold_ready", op_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", op_ready, 1);
        chk("bp_release_rv", res_valid, 0);
        @(negedge clk);
        chk("bp_next_sel", sel, 7'b0100000);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_idle", op_ready, 1);

        // Streaming opcodes 0..6
        collect = 1'b1; res_ready = 1'b1; op_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            int n;
            opcode = 3'(i);
            n = 0;
            while (!op_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!op_ready) begin
                tests++; fails++;
                $display("FAIL stream_timeout: op_ready=0, expected 1 for opcode %0d", i);
            end
            mux_out = 7'(i * 9 + 3);
            @(negedge clk);
        end
        op_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!op_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        collect = 1'b0;
        chk("stream_count", dq.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < dq.size()) chk("stream_result", dq[i], 7'(i * 9 + 3));
        end

        // Asynchronous reset in the middle of a multiply
        op_valid = 1'b1; opcode = 3'd6; mux_out = 7'h15; res_ready = 1'b1;
        @(negedge clk); op_valid = 1'b0;
        chk("rmid_sel1", sel, 7'b1000000);
        @(negedge clk);
        chk("rmid_sel2", sel, 7'b1000000);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_sel", sel, 0);
        chk("rmid_ready", op_ready, 1);
        chk("rmid_rv", res_valid, 0);
        chk("rmid_result", result, 0);
        chk("rmid_err", op_err, 0);
        chk("rmid_busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rv", res_valid, 0);
            chk("post_rst_ready", op_ready, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
